// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline interlock logic: opcode encodings,
// register-field widths, the hazard controller state type and opcode
// classification helpers (also used by the forwarding unit).
package hazard_ctrl_pkg;

  localparam int OPCODE_BITS    = 4;
  localparam int INSTR_REG_BITS = 5;

  localparam logic [OPCODE_BITS-1:0] OPCODE_OP = 4'd0;  // reg-reg ALU op
  localparam logic [OPCODE_BITS-1:0] OPCODE_LD = 4'd1;  // load
  localparam logic [OPCODE_BITS-1:0] OPCODE_ST = 4'd2;  // store
  localparam logic [OPCODE_BITS-1:0] OPCODE_BR = 4'd3;  // conditional branch
  localparam logic [OPCODE_BITS-1:0] OPCODE_JM = 4'd4;  // jump and link

  typedef enum logic [0:0] {
    HZ_RUN   = 1'b0,
    HZ_FLUSH = 1'b1
  } hz_state_e;

  // Opcode writes a destination register.
  function automatic logic is_writer(input logic [OPCODE_BITS-1:0] opcode);
    logic res;
    case (opcode)
      OPCODE_OP, OPCODE_LD, OPCODE_JM: res = 1'b1;
      default:                         res = 1'b0;
    endcase
    return res;
  endfunction

  // Opcode reads rs1.
  function automatic logic uses_rs1(input logic [OPCODE_BITS-1:0] opcode);
    logic res;
    case (opcode)
      OPCODE_OP, OPCODE_LD, OPCODE_ST, OPCODE_BR: res = 1'b1;
      default:                                    res = 1'b0;
    endcase
    return res;
  endfunction

  // Opcode reads rs2.
  function automatic logic uses_rs2(input logic [OPCODE_BITS-1:0] opcode);
    logic res;
    case (opcode)
      OPCODE_OP, OPCODE_ST, OPCODE_BR: res = 1'b1;
      default:                         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Scoreboard interlock and redirect flush controller beside the decode stage.
// Decides each cycle whether the decoded instruction issues, stalls fetch and
// decode on RAW hazards against in-flight writers, kills wrong-path work after
// an execute redirect, and keeps debug stall statistics.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_MAX    = 64,
  parameter int CNT_BITS     = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      dec_valid,
  input  logic [OPCODE_BITS-1:0]    dec_opcode,
  input  logic [INSTR_REG_BITS-1:0] dec_rs1,
  input  logic [INSTR_REG_BITS-1:0] dec_rs2,
  input  logic [INSTR_REG_BITS-1:0] dec_rd,
  input  logic                      wb_valid,
  input  logic [INSTR_REG_BITS-1:0] wb_rd,
  input  logic                      ex_redirect,
  output logic                      issue,
  output logic                      stall_fd,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [CNT_BITS-1:0]       stall_cnt,
  output logic                      deadlock
);

  localparam int FC_BITS  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int RUN_BITS = $clog2(STALL_MAX + 1);

  localparam logic [FC_BITS-1:0]  FC_LOAD  = FC_BITS'(FLUSH_CYCLES - 1);
  localparam logic [RUN_BITS-1:0] RUN_MAX  = RUN_BITS'(STALL_MAX);
  localparam logic [RUN_BITS-1:0] RUN_LAST = RUN_BITS'(STALL_MAX - 1);
  localparam logic [CNT_BITS-1:0] CNT_SAT  = {CNT_BITS{1'b1}};

  hz_state_e           state_q, state_d;
  logic [FC_BITS-1:0]  fcnt_q, fcnt_d;
  logic [31:0]         busy_q, busy_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [RUN_BITS-1:0] run_q, run_d;
  logic                dead_q, dead_d;
  logic                hazard_s;

  // RAW hazard against the registered scoreboard; writebacks are not bypassed.
  always_comb begin
    hazard_s = dec_valid &
               ((uses_rs1(dec_opcode) & busy_q[dec_rs1]) |
                (uses_rs2(dec_opcode) & busy_q[dec_rs2]));
  end

  // Issue/stall/flush decisions: reset, then redirect, then per-state behaviour.
  always_comb begin
    issue    = 1'b0;
    stall_fd = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    if (!reset_n) begin
      stall_fd = 1'b1;
    end else if (ex_redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (state_q == HZ_FLUSH) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      issue    = dec_valid & ~hazard_s;
      stall_fd = hazard_s;
      flush_e  = hazard_s;
    end
  end

  // Next state and flush down-counter; a redirect always (re)arms the flush window.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      HZ_RUN: begin
        if (ex_redirect) begin
          state_d = HZ_FLUSH;
          fcnt_d  = FC_LOAD;
        end else begin
          state_d = HZ_RUN;
        end
      end
      HZ_FLUSH: begin
        if (ex_redirect) begin
          fcnt_d = FC_LOAD;
        end else if (fcnt_q == {FC_BITS{1'b0}}) begin
          state_d = HZ_RUN;
        end else begin
          fcnt_d = fcnt_q - {{(FC_BITS-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = HZ_RUN;
        fcnt_d  = {FC_BITS{1'b0}};
      end
    endcase
  end

  // Scoreboard update: writeback clears first so a same-cycle issue set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) begin
      busy_d[wb_rd] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue && is_writer(dec_opcode) && (dec_rd != {INSTR_REG_BITS{1'b0}})) begin
      busy_d[dec_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Debug statistics: total stall cycles, consecutive stalls without progress, sticky deadlock.
  always_comb begin
    cnt_d  = cnt_q;
    run_d  = run_q;
    dead_d = dead_q;
    if (stall_fd && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    if (stall_fd && !wb_valid) begin
      if (run_q != RUN_MAX) begin
        run_d = run_q + {{(RUN_BITS-1){1'b0}}, 1'b1};
      end else begin
        run_d = run_q;
      end
      if (run_q == RUN_LAST) begin
        dead_d = 1'b1;
      end else begin
        dead_d = dead_q;
      end
    end else begin
      run_d = {RUN_BITS{1'b0}};
    end
  end

  // State, scoreboard and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= HZ_RUN;
      fcnt_q  <= {FC_BITS{1'b0}};
      busy_q  <= 32'd0;
      cnt_q   <= {CNT_BITS{1'b0}};
      run_q   <= {RUN_BITS{1'b0}};
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      dead_q  <= dead_d;
    end
  end

  // Debug outputs read as zero while reset is held.
  always_comb begin
    if (!reset_n) begin
      stall_cnt = {CNT_BITS{1'b0}};
      deadlock  = 1'b0;
    end else begin
      stall_cnt = cnt_q;
      deadlock  = dead_q;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (FLUSH_CYCLES=2, STALL_MAX=8).
// Control outputs are compared as {issue, stall_fd, flush_d, flush_e}.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      dec_valid;
  logic [OPCODE_BITS-1:0]    dec_opcode;
  logic [INSTR_REG_BITS-1:0] dec_rs1, dec_rs2, dec_rd;
  logic                      wb_valid;
  logic [INSTR_REG_BITS-1:0] wb_rd;
  logic                      ex_redirect;
  logic                      issue, stall_fd, flush_d, flush_e, deadlock;
  logic [31:0]               stall_cnt;
  logic [3:0]                ctl;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [3:0] C_IDLE  = 4'b0000;
  localparam logic [3:0] C_ISSUE = 4'b1000;
  localparam logic [3:0] C_STALL = 4'b0101;
  localparam logic [3:0] C_FLUSH = 4'b0011;
  localparam logic [3:0] C_RST   = 4'b0100;

  hazard_ctrl #(.FLUSH_CYCLES(2), .STALL_MAX(8), .CNT_BITS(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .dec_valid(dec_valid), .dec_opcode(dec_opcode),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .ex_redirect(ex_redirect),
    .issue(issue), .stall_fd(stall_fd), .flush_d(flush_d), .flush_e(flush_e),
    .stall_cnt(stall_cnt), .deadlock(deadlock)
  );

  always #5 clk = ~clk;

  assign ctl = {issue, stall_fd, flush_d, flush_e};

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic [3:0] op, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] rd);
    dec_valid  = v;
    dec_opcode = op;
    dec_rs1    = r1;
    dec_rs2    = r2;
    dec_rd     = rd;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd);
    wb_valid = v;
    wb_rd    = rd;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    ex_redirect = 1'b0;
    drv(1'b0, OPCODE_OP, 5'd0, 5'd0, 5'd0);
    wb(1'b0, 5'd0);
    adv();
    adv();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    ex_redirect = 1'b1;
    wb(1'b0, 5'd0);
    drv(1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd3);
    adv();
    half();
    n_cmp++;
    if (ctl !== C_RST) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RST); end
    n_cmp++;
    if (stall_cnt !== 32'd0 || deadlock !== 1'b0) begin
      n_bad++; $display("FAIL reset_dbg: got cnt=%0d dl=%b want 0 0", stall_cnt, deadlock);
    end
    adv();
    reset_n     = 1'b1;
    ex_redirect = 1'b0;
    half();
    n_cmp++;
    if (ctl !== C_ISSUE) begin n_bad++; $display("FAIL reset_first_run: got %b want %b", ctl, C_ISSUE); end
    adv();
  endtask

  task automatic test_independent();
    do_reset();
    drv(1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd5);
    half();
    n_cmp++;
    if (ctl !== C_ISSUE) begin n_bad++; $display("FAIL indep_op5: got %b want %b", ctl, C_ISSUE); end
    adv();
    drv(1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd6);
    half();
    n_cmp++;
    if (ctl !== C_ISSUE) begin n_bad++; $display("FAIL indep_op6: got %b want %b", ctl, C_ISSUE); end
    adv();
    drv(1'b0, OPCODE_OP, 5'd0, 5'd0, 5'd0);
    half();
    n_cmp++;
    if (ctl !== C_IDLE || stall_cnt !== 32'd0) begin
      n_bad++; $display("FAIL indep_idle: got %b cnt=%0d want %b cnt=0", ctl, stall_cnt, C_IDLE);
    end
    adv();
  endtask

  task automatic test_raw_stall();
    do_reset();
    drv(1'b1, OPCODE_LD, 5'd1, 5'd0, 5'd5);
    half();
    n_cmp++;
    if (ctl !== C_ISSUE) begin n_bad++; $display("FAIL raw_ld_issue: got %b want %b", ctl, C_ISSUE); end
    adv();
    drv(1'b1, OPCODE_OP, 5'd5, 5'd2, 5'd6);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) wb(1'b1, 5'd5);
      half();
      n_cmp++;
      if (ctl !== C_STALL) begin n_bad++; $display("FAIL raw_stall%0d: got %b want %b", i, ctl, C_STALL); end
      n_cmp++;
      if (stall_cnt !== 32'(i)) begin n_bad++; $display("FAIL raw_cnt%0d: got %0d want %0d", i, stall_cnt, i); end
      adv();
    end
    wb(1'b0, 5'd0);
    half();
    n_cmp++;
    if (ctl !== C_ISSUE) begin n_bad++; $display("FAIL raw_release: got %b want %b", ctl, C_ISSUE); end
    adv();
    drv(1'b0, OPCODE_OP, 5'd0, 5'd0, 5'd0);
    half();
    n_cmp++;
    if (stall_cnt !== 32'd3) begin n_bad++; $display("FAIL raw_total: got %0d want 3", stall_cnt); end
    adv();
  endtask

  task automatic test_x0_jm();
    do_reset();
    drv(1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd0);
    half();
    n_cmp++;
    if (ctl !== C_ISSUE) begin n_bad++; $display("FAIL x0_write: got %b want %b", ctl, C_ISSUE); end
    adv();
    drv(1'b1, OPCODE_OP, 5'd0, 5'd3, 5'd4);
    half();
    n_cmp++;
    if (ctl !== C_ISSUE) begin n_bad++; $display("FAIL x0_read: got %b want %b", ctl, C_ISSUE); end
    adv();
    drv(1'b1, OPCODE_JM, 5'd4, 5'd4, 5'd1);
    half();
    n_cmp++;
    if (ctl !== C_ISSUE) begin n_bad++; $display("FAIL jm_nosrc: got %b want %b", ctl, C_ISSUE); end
    adv();
    drv(1'b1, OPCODE_ST, 5'd2, 5'd1, 5'd0);
    half();
    n_cmp++;
    if (ctl !== C_STALL) begin n_bad++; $display("FAIL st_rs2_stall: got %b want %b", ctl, C_STALL); end
    adv();
    wb(1'b1, 5'd1);
    half();
    n_cmp++;
    if (ctl !== C_STALL) begin n_bad++; $display("FAIL st_wb_cycle: got %b want %b", ctl, C_STALL); end
    adv();
    wb(1'b0, 5'd0);
    half();
    n_cmp++;
    if (ctl !== C_ISSUE || stall_cnt !== 32'd2) begin
      n_bad++; $display("FAIL st_release: got %b cnt=%0d want %b cnt=2", ctl, stall_cnt, C_ISSUE);
    end
    adv();
  endtask

  task automatic test_same_cycle();
    do_reset();
    drv(1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd7);
    wb(1'b1, 5'd7);
    half();
    n_cmp++;
    if (ctl !== C_ISSUE) begin n_bad++; $display("FAIL setclr_issue: got %b want %b", ctl, C_ISSUE); end
    adv();
    wb(1'b0, 5'd0);
    drv(1'b1, OPCODE_BR, 5'd3, 5'd7, 5'd0);
    half();
    n_cmp++;
    if (ctl !== C_STALL) begin n_bad++; $display("FAIL setclr_busy: got %b want %b", ctl, C_STALL); end
    adv();
    wb(1'b1, 5'd7);
    adv();
    wb(1'b0, 5'd0);
    half();
    n_cmp++;
    if (ctl !== C_ISSUE) begin n_bad++; $display("FAIL setclr_release: got %b want %b", ctl, C_ISSUE); end
    adv();
  endtask

  task automatic test_redirect();
    do_reset();
    drv(1'b1, OPCODE_LD, 5'd1, 5'd0, 5'd9);
    adv();
    drv(1'b1, OPCODE_OP, 5'd9, 5'd2, 5'd3);
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      half();
      n_cmp++;
      if (ctl !== C_FLUSH) begin n_bad++; $display("FAIL redir_flush%0d: got %b want %b", i, ctl, C_FLUSH); end
      adv();
      ex_redirect = 1'b0;
    end
    half();
    n_cmp++;
    if (ctl !== C_STALL || stall_cnt !== 32'd0) begin
      n_bad++; $display("FAIL redir_back_run: got %b cnt=%0d want %b cnt=0", ctl, stall_cnt, C_STALL);
    end
    adv();
    // second redirect arrives in the first FLUSH cycle and re-arms the window
    ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      half();
      n_cmp++;
      if (ctl !== C_FLUSH) begin n_bad++; $display("FAIL reload_flush%0d: got %b want %b", i, ctl, C_FLUSH); end
      adv();
      ex_redirect = 1'b0;
      if (i == 0) ex_redirect = 1'b1;
    end
    half();
    n_cmp++;
    if (ctl !== C_STALL || stall_cnt !== 32'd1) begin
      n_bad++; $display("FAIL reload_back_run: got %b cnt=%0d want %b cnt=1", ctl, stall_cnt, C_STALL);
    end
    adv();
  endtask

  task automatic test_deadlock();
    do_reset();
    drv(1'b1, OPCODE_LD, 5'd1, 5'd0, 5'd10);
    adv();
    drv(1'b1, OPCODE_OP, 5'd10, 5'd2, 5'd11);
    for (int i = 1; i <= 8; i++) begin
      half();
      n_cmp++;
      if (ctl !== C_STALL || deadlock !== 1'b0) begin
        n_bad++; $display("FAIL dl_pre%0d: got %b dl=%b want %b dl=0", i, ctl, deadlock, C_STALL);
      end
      adv();
    end
    wb(1'b1, 5'd10);
    half();
    n_cmp++;
    if (deadlock !== 1'b1 || stall_cnt !== 32'd8) begin
      n_bad++; $display("FAIL dl_rise: got dl=%b cnt=%0d want dl=1 cnt=8", deadlock, stall_cnt);
    end
    adv();
    wb(1'b0, 5'd0);
    half();
    n_cmp++;
    if (ctl !== C_ISSUE || deadlock !== 1'b1 || stall_cnt !== 32'd9) begin
      n_bad++; $display("FAIL dl_sticky: got %b dl=%b cnt=%0d want %b dl=1 cnt=9", ctl, deadlock, stall_cnt, C_ISSUE);
    end
    adv();
    // reset mid-stall: scoreboard empties and deadlock clears
    drv(1'b1, OPCODE_LD, 5'd1, 5'd0, 5'd12);
    adv();
    drv(1'b1, OPCODE_OP, 5'd12, 5'd2, 5'd13);
    half();
    n_cmp++;
    if (ctl !== C_STALL) begin n_bad++; $display("FAIL rst_mid_stall: got %b want %b", ctl, C_STALL); end
    adv();
    reset_n = 1'b0;
    adv();
    reset_n = 1'b1;
    half();
    n_cmp++;
    if (ctl !== C_ISSUE || deadlock !== 1'b0 || stall_cnt !== 32'd0) begin
      n_bad++; $display("FAIL rst_clears: got %b dl=%b cnt=%0d want %b dl=0 cnt=0", ctl, deadlock, stall_cnt, C_ISSUE);
    end
    adv();
  endtask

  initial begin
    reset_n     = 1'b0;
    ex_redirect = 1'b0;
    drv(1'b0, OPCODE_OP, 5'd0, 5'd0, 5'd0);
    wb(1'b0, 5'd0);
    adv();
    test_reset();
    test_independent();
    test_raw_stall();
    test_x0_jm();
    test_same_cycle();
    test_redirect();
    test_deadlock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Scoreboard-based interlock and flush controller for the in-order pipeline. Sits beside the decode stage and decides every cycle whether the decoded instruction may issue to execute. It stalls fetch/decode on read-after-write hazards against in-flight writers and kills wrong-path work after an execute-stage redirect. It also keeps a saturating stall counter and a sticky deadlock flag for debug.

## Interface
- FLUSH_CYCLES, 1: bubble cycles forced after a redirect (≥1).
- STALL_MAX, 64: consecutive stall cycles before deadlock is flagged.
- CNT_BITS, 32: stall counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- dec_valid  in  1  decode holds a valid instruction.
- dec_opcode  in  OPCODE_BITS  opcode of decode instruction.
- dec_rs1, dec_rs2, dec_rd  in  INSTR_REG_BITS  register fields of decode instruction.
- wb_valid  in  1  writeback commits a register this cycle.
- wb_rd  in  INSTR_REG_BITS  register written by writeback.
- ex_redirect  in  1  branch taken / jump resolved in execute (1-cycle pulse).
- issue  out  1  decode instruction advances to execute this cycle.
- stall_fd  out  1  hold PC and fetch/decode registers.
- flush_d  out  1  invalidate decode register.
- flush_e  out  1  insert bubble into execute.
- stall_cnt  out  CNT_BITS  saturating count of stall cycles.
- deadlock  out  1  sticky: stall persisted STALL_MAX cycles.

## Operation
- Scoreboard: 32-bit busy vector, bit 0 hardwired 0.
- Writer: opcode in {OPCODE_OP, OPCODE_LD, OPCODE_JM} with rd≠0. On issue of a writer, set busy[rd].
- wb_valid clears busy[wb_rd]. When a set and a clear hit the same register in one cycle, the set wins.
- Source use: rs1 is used by OP, LD, ST, BR. rs2 is used by OP, ST, BR. JM uses neither.
- hazard = dec_valid & ((use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2])), evaluated on the registered busy vector. There is no writeback bypass: a clear becomes visible the next cycle.
- FSM states:
  - RUN: issue = dec_valid & ~hazard. stall_fd = dec_valid & hazard. flush_e = stall_fd.
  - FLUSH: issue = 0. stall_fd = 0. flush_d = 1. flush_e = 1. A down-counter loads FLUSH_CYCLES-1.
- Transitions:
  - RUN→FLUSH on ex_redirect.
  - FLUSH→RUN when the counter reaches 0.
  - ex_redirect during FLUSH reloads the counter.
- In the ex_redirect cycle (any state), these outputs are forced regardless of hazard: flush_d = 1, flush_e = 1, issue = 0, stall_fd = 0.
- stall_cnt increments on each cycle with stall_fd = 1 and saturates at all-ones.
- Stall-run counter:
  - Increments while stall_fd = 1 and wb_valid = 0.
  - Clears on any cycle with stall_fd = 0 or wb_valid = 1.
  - deadlock sets when it reaches STALL_MAX and stays set until reset.

## Timing
- Reset values: busy = 0, state = RUN, counters = 0, deadlock = 0. During reset all outputs are 0 except stall_fd = 1.
- First cycle after reset: normal RUN behaviour.
- issue, stall_fd, flush_d and flush_e are combinational from registered state and current inputs (same-cycle). Scoreboard updates are visible the following cycle.
- Load-use dependency with a 3-stage writer latency: decode stalls until the cycle after the wb_valid that clears the register.
- Reset asserted mid-stall or mid-flush returns to RUN with an empty scoreboard next cycle.

## Structure
- The following go in PARAMS_pkg: the state enum typedef (HZ_RUN, HZ_FLUSH) and helper functions is_writer(opcode), uses_rs1(opcode) and uses_rs2(opcode). These are shared with the forwarding unit.
- No sub-module. The scoreboard is a 32-bit register inside the block.
- Target size: ~150–250 lines.

## Test plan
- Independent ops: OP x5 then OP x6, rs1 = x1, rs2 = x2, no busy bits → issue = 1 both cycles, stall_cnt = 0.
- RAW stall: LD x5 issues, next decode OP rs1 = x5 → stall_fd = 1, flush_e = 1 until the cycle after wb_valid with wb_rd = 5, then issue = 1. stall_cnt equals the number of stall cycles.
- x0 and JM: OP rd = x0 then OP rs1 = x0 → no stall. JM rd = x1 followed by ST rs2 = x1 → stall until x1 writes back.
- Same-cycle set/clear: wb_rd = 7 while issuing OP rd = 7 → busy[7] = 1 afterward.
- Redirect: ex_redirect pulse with FLUSH_CYCLES = 2 while decode is hazarded → flush_d = flush_e = 1 for 3 cycles (pulse + 2), issue = 0, then RUN.
- Deadlock: STALL_MAX = 8, hold a hazard with no writeback → deadlock rises on the 8th stall cycle and stays set after the stall clears. reset_n = 0 clears it.
